// File: rtl/i2s_led_mask.sv
`default_nettype none
// ============================================================================
// Module   : i2s_led_mask
// Purpose  : Frame-position tracker that forwards one tile's bits from a
//            serial pixel stream to an LED panel and drives its latch/OE/row.
// Revision : 1.0
// ============================================================================
module i2s_led_mask #(
   parameter int PANEL_W = 32,
   parameter int PANEL_H = 16,
   parameter int NUM_X   = 16,
   parameter int NUM_Y   = 16
) (
   input  logic       i2s_clk,
   input  logic       rst,
   input  logic       i2s_data,
   input  logic [3:0] addr_x,
   input  logic [3:0] addr_y,
   output logic [5:0] row_num,
   output logic       led_data,
   output logic       led_clk,
   output logic       led_lat,
   output logic       led_oe
);

   localparam int BW = (PANEL_W > 1) ? $clog2(PANEL_W) : 1;

   localparam logic [BW-1:0] c_B_LAST = BW'(PANEL_W - 1);
   localparam logic [3:0]    c_X_LAST = 4'(NUM_X - 1);
   localparam logic [5:0]    c_R_LAST = 6'(PANEL_H - 1);
   localparam logic [3:0]    c_Y_LAST = 4'(NUM_Y - 1);

   logic [BW-1:0] r_b;
   logic [3:0]    r_x;
   logic [5:0]    r_r;
   logic [3:0]    r_y;

   logic          r_shift_en;
   logic          r_led_data;
   logic          r_lat_pend;
   logic [5:0]    r_row_cap;
   logic          r_led_lat;
   logic          r_led_oe;
   logic [5:0]    r_row_num;

   logic          w_b_last;
   logic          w_x_last;
   logic          w_r_last;
   logic          w_y_last;
   logic          w_sel;
   logic          w_cap_last;

   assign w_b_last   = (r_b == c_B_LAST);
   assign w_x_last   = (r_x == c_X_LAST);
   assign w_r_last   = (r_r == c_R_LAST);
   assign w_y_last   = (r_y == c_Y_LAST);

   // Counters never exceed NUM_X-1/NUM_Y-1, so out-of-range addresses never match.
   assign w_sel      = (r_x == addr_x) && (r_y == addr_y);
   assign w_cap_last = w_sel && w_b_last;

   // Mixed-radix frame position: y (MSB), r, x, b (LSB).
   always_ff @(posedge i2s_clk or posedge rst) begin
      if (rst) begin
         r_b <= '0;
         r_x <= '0;
         r_r <= '0;
         r_y <= '0;
      end else if (!w_b_last) begin
         r_b <= r_b + 1'b1;
      end else begin
         r_b <= '0;
         if (!w_x_last) begin
            r_x <= r_x + 1'b1;
         end else begin
            r_x <= '0;
            if (!w_r_last) begin
               r_r <= r_r + 1'b1;
            end else begin
               r_r <= '0;
               r_y <= w_y_last ? 4'd0 : r_y + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i2s_clk or posedge rst) begin
      if (rst) begin
         r_shift_en <= 1'b0;
         r_led_data <= 1'b0;
      end else begin
         r_shift_en <= w_sel;
         if (w_sel) begin
            r_led_data <= i2s_data;
         end
      end
   end

   // Latch sequencing runs independently of the frame counters, so a latch
   // coinciding with the frame wrap completes unaffected.
   always_ff @(posedge i2s_clk or posedge rst) begin
      if (rst) begin
         r_lat_pend <= 1'b0;
         r_row_cap  <= '0;
         r_led_lat  <= 1'b0;
         r_led_oe   <= 1'b1;
         r_row_num  <= '0;
      end else begin
         r_led_lat <= r_lat_pend;
         if (w_cap_last) begin
            r_lat_pend <= 1'b1;
            r_row_cap  <= r_r;
         end else if (r_lat_pend) begin
            r_lat_pend <= 1'b0;
         end
         if (r_lat_pend) begin
            r_led_oe  <= 1'b1;
            r_row_num <= r_row_cap;
         end else if (r_led_lat) begin
            r_led_oe  <= 1'b0;
         end
      end
   end

   // Shift pulse occupies the low half of the cycle after each captured bit.
   assign led_clk  = r_shift_en & ~i2s_clk;
   assign led_data = r_led_data;
   assign led_lat  = r_led_lat;
   assign led_oe   = r_led_oe;
   assign row_num  = r_row_num;

endmodule
`default_nettype wire

// File: tb/tb_i2s_led_mask.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_led_mask
// Purpose  : Directed self-checking bench for i2s_led_mask.
// Revision : 1.0
// ============================================================================
module tb_i2s_led_mask;

   logic       i2s_clk;
   logic       rst;
   logic       rst2;
   logic       i2s_data;
   logic [3:0] addr_x;
   logic [3:0] addr_y;
   logic [5:0] row_num;
   logic       led_data;
   logic       led_clk;
   logic       led_lat;
   logic       led_oe;
   logic [5:0] row_num2;
   logic       led_data2;
   logic       led_clk2;
   logic       led_lat2;
   logic       led_oe2;

   int n_pass;
   int n_total;

   i2s_led_mask dut (
      .i2s_clk  (i2s_clk),
      .rst      (rst),
      .i2s_data (i2s_data),
      .addr_x   (addr_x),
      .addr_y   (addr_y),
      .row_num  (row_num),
      .led_data (led_data),
      .led_clk  (led_clk),
      .led_lat  (led_lat),
      .led_oe   (led_oe)
   );

   // Narrow array (NUM_X=4) addressed out of range at column 15.
   i2s_led_mask #(.PANEL_W(32), .PANEL_H(4), .NUM_X(4), .NUM_Y(16)) dut2 (
      .i2s_clk  (i2s_clk),
      .rst      (rst2),
      .i2s_data (i2s_data),
      .addr_x   (4'd15),
      .addr_y   (4'd0),
      .row_num  (row_num2),
      .led_data (led_data2),
      .led_clk  (led_clk2),
      .led_lat  (led_lat2),
      .led_oe   (led_oe2)
   );

   initial begin
      i2s_clk = 1'b0;
      forever #5 i2s_clk = ~i2s_clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Drive one bit, let one rising edge consume it, return in the low phase.
   task automatic tick(input logic d);
      i2s_data = d;
      @(posedge i2s_clk);
      @(negedge i2s_clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      @(posedge i2s_clk);
      @(negedge i2s_clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic d;
      logic [31:0] pulses;
      logic [31:0] lats;
      logic [31:0] oe_low;
      logic [31:0] first_pulse;
      logic [31:0] first_lat;
      logic [31:0] bad;

      n_pass   = 0;
      n_total  = 0;
      i2s_data = 1'b0;
      addr_x   = 4'd0;
      addr_y   = 4'd0;
      rst      = 1'b1;
      rst2     = 1'b1;
      repeat (3) @(negedge i2s_clk);
      #1;

      check("rst_led_clk",  {31'd0, led_clk},  32'd0);
      check("rst_led_lat",  {31'd0, led_lat},  32'd0);
      check("rst_led_oe",   {31'd0, led_oe},   32'd1);
      check("rst_row_num",  {26'd0, row_num},  32'd0);
      check("rst_led_data", {31'd0, led_data}, 32'd0);
      rst = 1'b0;

      // Baseline: edge 1 also checks the clock-high half has no shift pulse.
      d = 1'b1;
      i2s_data = d;
      @(posedge i2s_clk);
      #1;
      check("base_clk_high_phase", {31'd0, led_clk}, 32'd0);
      @(negedge i2s_clk);
      #1;
      check("base_e1_data", {31'd0, led_data}, {31'd0, d});
      bad = 0;
      for (int n = 2; n <= 32; n++) begin
         d = 1'($urandom_range(0, 1));
         tick(d);
         if (led_data !== d || led_clk !== 1'b1 || led_lat !== 1'b0 || led_oe !== 1'b1)
            bad++;
      end
      check("base_capture_e2_32", bad, 32'd0);
      tick(1'b0);
      check("base_e33_lat", {31'd0, led_lat}, 32'd1);
      check("base_e33_oe",  {31'd0, led_oe},  32'd1);
      check("base_e33_clk", {31'd0, led_clk}, 32'd0);
      check("base_e33_row", {26'd0, row_num}, 32'd0);
      tick(1'b0);
      check("base_e34_lat", {31'd0, led_lat}, 32'd0);
      check("base_e34_oe",  {31'd0, led_oe},  32'd0);

      // Gap until the next row segment of this tile.
      pulses = 0;
      lats   = 0;
      oe_low = 0;
      for (int n = 35; n <= 512; n++) begin
         tick(1'($urandom_range(0, 1)));
         pulses += {31'd0, led_clk};
         lats   += {31'd0, led_lat};
         oe_low += {31'd0, ~led_oe};
      end
      check("gap_pulses", pulses, 32'd0);
      check("gap_lats",   lats,   32'd0);
      check("gap_oe_low", oe_low, 32'd478);
      bad = 0;
      for (int n = 513; n <= 544; n++) begin
         d = 1'($urandom_range(0, 1));
         tick(d);
         if (led_data !== d || led_clk !== 1'b1) bad++;
      end
      check("row1_capture", bad, 32'd0);
      tick(1'b0);
      check("row1_lat", {31'd0, led_lat}, 32'd1);
      check("row1_row", {26'd0, row_num}, 32'd1);
      tick(1'b0);
      check("row1_oe_after", {31'd0, led_oe}, 32'd0);

      // Mid-segment reset after 20 bits of row 2.
      for (int n = 547; n <= 1044; n++) tick(1'b1);
      check("mid_pre_clk", {31'd0, led_clk}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_clk",  {31'd0, led_clk},  32'd0);
      check("mid_rst_oe",   {31'd0, led_oe},   32'd1);
      check("mid_rst_row",  {26'd0, row_num},  32'd0);
      check("mid_rst_data", {31'd0, led_data}, 32'd0);
      @(posedge i2s_clk);
      @(negedge i2s_clk);
      #1;
      rst = 1'b0;
      lats = 0;
      pulses = 0;
      for (int n = 1; n <= 32; n++) begin
         tick(1'($urandom_range(0, 1)));
         lats   += {31'd0, led_lat};
         pulses += {31'd0, led_clk};
      end
      check("mid_no_early_lat", lats,   32'd0);
      check("mid_pulses",       pulses, 32'd32);
      tick(1'b0);
      check("mid_lat", {31'd0, led_lat}, 32'd1);
      check("mid_row", {26'd0, row_num}, 32'd0);

      // Column select: tile (3,0), all 16 rows of tile row 0.
      addr_x = 4'd3;
      reset_pulse();
      pulses = 0;
      lats = 0;
      first_pulse = 0;
      first_lat = 0;
      for (int n = 1; n <= 8200; n++) begin
         tick(1'($urandom_range(0, 1)));
         if (led_clk === 1'b1) begin
            pulses++;
            if (first_pulse == 0) first_pulse = n;
         end
         if (led_lat === 1'b1) begin
            if (first_lat == 0) first_lat = n;
            check("col_row_num", {26'd0, row_num}, lats);
            lats++;
         end
      end
      check("col_first_pulse", first_pulse, 32'd97);
      check("col_first_lat",   first_lat,   32'd129);
      check("col_pulses",      pulses,      32'd512);
      check("col_lats",        lats,        32'd16);

      // Tile row select: tile (0,1) is idle for the whole of tile row 0.
      addr_x = 4'd0;
      addr_y = 4'd1;
      reset_pulse();
      pulses = 0;
      first_pulse = 0;
      first_lat = 0;
      for (int n = 1; n <= 8230; n++) begin
         tick(1'($urandom_range(0, 1)));
         if (led_clk === 1'b1) begin
            pulses++;
            if (first_pulse == 0) first_pulse = n;
         end
         if (led_lat === 1'b1 && first_lat == 0) begin
            first_lat = n;
            check("trow_row_num", {26'd0, row_num}, 32'd0);
         end
      end
      check("trow_first_pulse", first_pulse, 32'd8193);
      check("trow_first_lat",   first_lat,   32'd8225);
      check("trow_pulses",      pulses,      32'd32);

      // Out-of-range column on the narrow array, over one full frame.
      rst2 = 1'b0;
      pulses = 0;
      lats = 0;
      oe_low = 0;
      for (int n = 1; n <= 8200; n++) begin
         tick(1'($urandom_range(0, 1)));
         pulses += {31'd0, led_clk2};
         lats   += {31'd0, led_lat2};
         oe_low += {31'd0, ~led_oe2};
      end
      check("oor_pulses", pulses, 32'd0);
      check("oor_lats",   lats,   32'd0);
      check("oor_oe_low", oe_low, 32'd0);
      check("oor_row",    {26'd0, row_num2},  32'd0);
      check("oor_data",   {31'd0, led_data2}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
